// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch reads and memory-stage loads/stores, with a timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the grant when fetch and data requests tie.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned AW             = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IReqF,
  input  logic [AW-1:0] IAddrF,
  input  logic          IFlushF,
  output logic [31:0]   IRdataF,
  output logic          IReadyF,
  input  logic          DReqM,
  input  logic          DWeM,
  input  logic [AW-1:0] DAddrM,
  input  logic [31:0]   DWdataM,
  input  logic [3:0]    DByteEnM,
  output logic [31:0]   DRdataM,
  output logic          DReadyM,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemWdata,
  output logic [3:0]    MemByteEn,
  input  logic [31:0]   MemRdata,
  input  logic          MemAck,
  output logic          ArbStallF,
  output logic          ArbStallM,
  output logic          ErrTimeout
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IBUSY = 2'd1;
  localparam logic [1:0] S_DBUSY = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   irdata_q, irdata_d;
  logic          iready_q, iready_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          dready_q, dready_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          discard_q, discard_d;
  logic          discard_now;
  logic          fetch_ok;
  logic          grant_d;
  logic          grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when data was served last; reset leaves it set so fetch wins the first tie.
  logic          last_data_q, last_data_d;
`endif

  assign fetch_ok = IReqF & ~IFlushF;

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = DReqM & (~fetch_ok | ~last_data_q);
`else
  assign grant_d = DReqM;
`endif
  assign grant_i = ~grant_d & fetch_ok;

  assign MemReq     = mem_req_q;
  assign MemWe      = mem_we_q;
  assign MemAddr    = mem_addr_q;
  assign MemWdata   = mem_wdata_q;
  assign MemByteEn  = mem_be_q;
  assign IRdataF    = irdata_q;
  assign IReadyF    = iready_q;
  assign DRdataM    = drdata_q;
  assign DReadyM    = dready_q;
  assign ErrTimeout = err_q;
  assign ArbStallF  = IReqF & ~iready_q;
  assign ArbStallM  = DReqM & ~dready_q;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    irdata_d    = irdata_q;
    iready_d    = 1'b0;
    drdata_d    = drdata_q;
    dready_d    = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    discard_now = discard_q | IFlushF;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        discard_d = 1'b0;
        if (grant_d) begin
          state_d     = S_DBUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = DWeM;
          mem_addr_d  = DAddrM;
          mem_wdata_d = DWeM ? DWdataM : 32'h0;
          mem_be_d    = DWeM ? DByteEnM : 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_d = 1'b1;
`endif
        end else if (grant_i) begin
          state_d     = S_IBUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = IAddrF;
          mem_wdata_d = 32'h0;
          mem_be_d    = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_d = 1'b0;
`endif
        end
      end

      S_IBUSY: begin
        discard_d = discard_now;
        // A flushed fetch still completes on the bus but is not reported.
        if (MemAck) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          if (!discard_now) begin
            irdata_d = MemRdata;
            iready_d = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!discard_now) begin
            irdata_d = NOP_INSN;
            iready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DBUSY: begin
        if (MemAck) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          drdata_d  = mem_we_q ? 32'h0 : MemRdata;
          dready_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          drdata_d  = 32'h0;
          dready_d  = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      irdata_q    <= '0;
      iready_q    <= 1'b0;
      drdata_q    <= '0;
      dready_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      irdata_q    <= irdata_d;
      iready_q    <= iready_d;
      drdata_q    <= drdata_d;
      dready_q    <= dready_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (default fixed priority, TIMEOUT_CYCLES=4).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          reset;
  logic          IReqF;
  logic [AW-1:0] IAddrF;
  logic          IFlushF;
  logic [31:0]   IRdataF;
  logic          IReadyF;
  logic          DReqM;
  logic          DWeM;
  logic [AW-1:0] DAddrM;
  logic [31:0]   DWdataM;
  logic [3:0]    DByteEnM;
  logic [31:0]   DRdataM;
  logic          DReadyM;
  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWdata;
  logic [3:0]    MemByteEn;
  logic [31:0]   MemRdata;
  logic          MemAck;
  logic          ArbStallF;
  logic          ArbStallM;
  logic          ErrTimeout;

  int tests_run = 0;
  int failures  = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .IReqF(IReqF), .IAddrF(IAddrF), .IFlushF(IFlushF), .IRdataF(IRdataF), .IReadyF(IReadyF),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM), .DByteEnM(DByteEnM),
    .DRdataM(DRdataM), .DReadyM(DReadyM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemByteEn(MemByteEn), .MemRdata(MemRdata), .MemAck(MemAck),
    .ArbStallF(ArbStallF), .ArbStallM(ArbStallM), .ErrTimeout(ErrTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++; if (MemReq !== 1'b0) begin failures++; $display("FAIL rst_memreq: got %b expected 0", MemReq); end
    tests_run++; if (MemAddr !== 32'h0) begin failures++; $display("FAIL rst_memaddr: got %h expected 0", MemAddr); end
    tests_run++; if (MemByteEn !== 4'h0) begin failures++; $display("FAIL rst_byteen: got %h expected 0", MemByteEn); end
    tests_run++; if (IReadyF !== 1'b0 || DReadyM !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b%b expected 00", IReadyF, DReadyM); end
    tests_run++; if (IRdataF !== 32'h0 || DRdataM !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h/%h expected 0/0", IRdataF, DRdataM); end
    tests_run++; if (ErrTimeout !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", ErrTimeout); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    tick();
    IReqF = 1'b1; IAddrF = 32'h100;
    #1;
    tests_run++; if (ArbStallF !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0: got %b expected 1", ArbStallF); end
    tick();
    tests_run++; if (MemReq !== 1'b1) begin failures++; $display("FAIL fetch_memreq_c1: got %b expected 1", MemReq); end
    tests_run++; if (MemAddr !== 32'h100) begin failures++; $display("FAIL fetch_addr_c1: got %h expected 00000100", MemAddr); end
    tests_run++; if (MemWe !== 1'b0 || MemByteEn !== 4'hF) begin failures++; $display("FAIL fetch_we_be_c1: got %b/%h expected 0/f", MemWe, MemByteEn); end
    tests_run++; if (ArbStallF !== 1'b1) begin failures++; $display("FAIL fetch_stall_c1: got %b expected 1", ArbStallF); end
    tick();
    MemAck = 1'b1; MemRdata = 32'h0050_0093;
    #1;
    tests_run++; if (ArbStallF !== 1'b1 || IReadyF !== 1'b0) begin failures++; $display("FAIL fetch_c2: got stall=%b ready=%b expected 1/0", ArbStallF, IReadyF); end
    tick();
    MemAck = 1'b0;
    tests_run++; if (IReadyF !== 1'b1) begin failures++; $display("FAIL fetch_ready_c3: got %b expected 1", IReadyF); end
    tests_run++; if (IRdataF !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata_c3: got %h expected 00500093", IRdataF); end
    tests_run++; if (MemReq !== 1'b0) begin failures++; $display("FAIL fetch_memreq_c3: got %b expected 0", MemReq); end
    tests_run++; if (ArbStallF !== 1'b0) begin failures++; $display("FAIL fetch_stall_c3: got %b expected 0", ArbStallF); end
    IReqF = 1'b0;
    tick();
    tests_run++; if (IReadyF !== 1'b0) begin failures++; $display("FAIL fetch_pulse_c4: got %b expected 0", IReadyF); end
    tick();
    tests_run++; if (MemReq !== 1'b0) begin failures++; $display("FAIL fetch_idle_c5: got %b expected 0", MemReq); end
  endtask

  task automatic test_priority();
    IReqF = 1'b1; IAddrF = 32'h300;
    DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h400;
    tick();
    tests_run++; if (MemAddr !== 32'h400) begin failures++; $display("FAIL prio_data_first: got %h expected 00000400", MemAddr); end
    tests_run++; if (ArbStallF !== 1'b1 || ArbStallM !== 1'b1) begin failures++; $display("FAIL prio_stalls: got %b%b expected 11", ArbStallF, ArbStallM); end
    MemAck = 1'b1; MemRdata = 32'hCAFE_0001;
    tick();
    MemAck = 1'b0;
    tests_run++; if (DReadyM !== 1'b1 || DRdataM !== 32'hCAFE_0001) begin failures++; $display("FAIL prio_load_resp: got %b/%h expected 1/cafe0001", DReadyM, DRdataM); end
    tests_run++; if (IReadyF !== 1'b0) begin failures++; $display("FAIL prio_no_iready: got %b expected 0", IReadyF); end
    DReqM = 1'b0;
    tick();
    tests_run++; if (MemReq !== 1'b0 || DReadyM !== 1'b0) begin failures++; $display("FAIL prio_resp_gap: got req=%b dready=%b expected 0/0", MemReq, DReadyM); end
    tick();
    tests_run++; if (MemReq !== 1'b1 || MemAddr !== 32'h300) begin failures++; $display("FAIL prio_fetch_second: got %b/%h expected 1/00000300", MemReq, MemAddr); end
    MemAck = 1'b1; MemRdata = 32'h1111_2222;
    tick();
    MemAck = 1'b0;
    tests_run++; if (IReadyF !== 1'b1 || IRdataF !== 32'h1111_2222) begin failures++; $display("FAIL prio_fetch_resp: got %b/%h expected 1/11112222", IReadyF, IRdataF); end
    IReqF = 1'b0;
    tick();
    tests_run++; if (IReadyF !== 1'b0) begin failures++; $display("FAIL prio_fetch_pulse: got %b expected 0", IReadyF); end
  endtask

  task automatic test_store();
    tick();
    DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h2000; DWdataM = 32'hDEAD_BEEF; DByteEnM = 4'b0011;
    tick();
    tests_run++; if (MemReq !== 1'b1 || MemWe !== 1'b1) begin failures++; $display("FAIL store_req_we: got %b%b expected 11", MemReq, MemWe); end
    tests_run++; if (MemAddr !== 32'h2000) begin failures++; $display("FAIL store_addr: got %h expected 00002000", MemAddr); end
    tests_run++; if (MemWdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_wdata: got %h expected deadbeef", MemWdata); end
    tests_run++; if (MemByteEn !== 4'b0011) begin failures++; $display("FAIL store_byteen: got %b expected 0011", MemByteEn); end
    MemAck = 1'b1; MemRdata = 32'h5555_5555;
    tick();
    MemAck = 1'b0;
    tests_run++; if (DReadyM !== 1'b1 || DRdataM !== 32'h0) begin failures++; $display("FAIL store_resp: got %b/%h expected 1/00000000", DReadyM, DRdataM); end
    DReqM = 1'b0; DWeM = 1'b0;
    tick();
    tests_run++; if (DReadyM !== 1'b0) begin failures++; $display("FAIL store_pulse: got %b expected 0", DReadyM); end
    tick();
    tests_run++; if (MemReq !== 1'b0) begin failures++; $display("FAIL store_idle: got %b expected 0", MemReq); end
  endtask

  // Ack lands on the same cycle the timeout would fire: the ack must win.
  task automatic test_flush();
    IReqF = 1'b1; IAddrF = 32'h500;
    tick();
    tests_run++; if (MemReq !== 1'b1 || MemAddr !== 32'h500) begin failures++; $display("FAIL flush_grant: got %b/%h expected 1/00000500", MemReq, MemAddr); end
    IFlushF = 1'b1;
    tick();
    IFlushF = 1'b0; IReqF = 1'b0;
    tick();
    tick();
    tests_run++; if (MemReq !== 1'b1) begin failures++; $display("FAIL flush_held: got %b expected 1", MemReq); end
    MemAck = 1'b1; MemRdata = 32'hBADB_AD00;
    tick();
    MemAck = 1'b0;
    tests_run++; if (IReadyF !== 1'b0) begin failures++; $display("FAIL flush_no_ready: got %b expected 0", IReadyF); end
    tests_run++; if (IRdataF !== 32'h1111_2222) begin failures++; $display("FAIL flush_rdata_kept: got %h expected 11112222", IRdataF); end
    tests_run++; if (MemReq !== 1'b0) begin failures++; $display("FAIL flush_memreq_drop: got %b expected 0", MemReq); end
    tests_run++; if (ErrTimeout !== 1'b0) begin failures++; $display("FAIL ack_beats_timeout: got %b expected 0", ErrTimeout); end
    tick();
    tests_run++; if (IReadyF !== 1'b0 || MemReq !== 1'b0) begin failures++; $display("FAIL flush_after: got ready=%b req=%b expected 0/0", IReadyF, MemReq); end
  endtask

  task automatic test_timeout();
    IReqF = 1'b1; IAddrF = 32'h600;
    tick();
    tick();
    tick();
    tick();
    tests_run++; if (MemReq !== 1'b1 || ErrTimeout !== 1'b0) begin failures++; $display("FAIL to_busy_c4: got req=%b err=%b expected 1/0", MemReq, ErrTimeout); end
    tick();
    tests_run++; if (IReadyF !== 1'b1 || IRdataF !== 32'h0000_0013) begin failures++; $display("FAIL to_nop: got %b/%h expected 1/00000013", IReadyF, IRdataF); end
    tests_run++; if (ErrTimeout !== 1'b1 || MemReq !== 1'b0) begin failures++; $display("FAIL to_err_set: got err=%b req=%b expected 1/0", ErrTimeout, MemReq); end
    IReqF = 1'b0;
    tick();
    tick();
    tests_run++; if (ErrTimeout !== 1'b1 || IReadyF !== 1'b0) begin failures++; $display("FAIL to_err_sticky: got err=%b ready=%b expected 1/0", ErrTimeout, IReadyF); end
  endtask

  task automatic test_reset_mid();
    DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h700;
    tick();
    tests_run++; if (MemReq !== 1'b1) begin failures++; $display("FAIL rstmid_grant: got %b expected 1", MemReq); end
    reset = 1'b1;
    tick();
    tests_run++; if (MemReq !== 1'b0 || DReadyM !== 1'b0 || ErrTimeout !== 1'b0) begin failures++; $display("FAIL rstmid_clear: got req=%b dready=%b err=%b expected 0/0/0", MemReq, DReadyM, ErrTimeout); end
    reset = 1'b0;
    tick();
    tests_run++; if (MemReq !== 1'b1 || MemAddr !== 32'h700) begin failures++; $display("FAIL rstmid_regrant: got %b/%h expected 1/00000700", MemReq, MemAddr); end
    MemAck = 1'b1; MemRdata = 32'h0000_0077;
    tick();
    MemAck = 1'b0;
    tests_run++; if (DReadyM !== 1'b1 || DRdataM !== 32'h0000_0077) begin failures++; $display("FAIL rstmid_resp: got %b/%h expected 1/00000077", DReadyM, DRdataM); end
    DReqM = 1'b0;
    tick();
    tests_run++; if (DReadyM !== 1'b0) begin failures++; $display("FAIL rstmid_pulse: got %b expected 0", DReadyM); end
  endtask

  initial begin
    reset = 1'b1; IReqF = 1'b0; IAddrF = '0; IFlushF = 1'b0;
    DReqM = 1'b0; DWeM = 1'b0; DAddrM = '0; DWdataM = '0; DByteEnM = '0;
    MemRdata = '0; MemAck = 1'b0;
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
